dmi_dtm_core: RTL and testbench

DMI_DTM_CORE -- requirements
Module: dmi_dtm_core

---
 rtl/dmi_dtm_core_if.sv | 30 +++
 rtl/dmi_dtm_core.sv | 166 ++++++++++++++++
 tb/tb_dmi_dtm_core.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmi_dtm_core_if.sv
// DMI request/response channel between the DTM core and the debug module.
interface dmi_dtm_core_if #(
  parameter int unsigned AddrWidth = 7
);
  logic                 dmi_req_valid_o;
  logic                 dmi_req_ready_i;
  logic [AddrWidth-1:0] dmi_req_addr_o;
  logic [1:0]           dmi_req_op_o;
  logic [31:0]          dmi_req_data_o;
  logic                 dmi_resp_valid_i;
  logic                 dmi_resp_ready_o;
  logic [31:0]          dmi_resp_data_i;
  logic [1:0]           dmi_resp_resp_i;

  modport master (
    output dmi_req_valid_o, dmi_req_addr_o,
    output dmi_req_op_o, dmi_req_data_o,
    output dmi_resp_ready_o,
    input  dmi_req_ready_i, dmi_resp_valid_i,
    input  dmi_resp_data_i, dmi_resp_resp_i
  );

  modport slave (
    input  dmi_req_valid_o, dmi_req_addr_o,
    input  dmi_req_op_o, dmi_req_data_o,
    input  dmi_resp_ready_o,
    output dmi_req_ready_i, dmi_resp_valid_i,
    output dmi_resp_data_i, dmi_resp_resp_i
  );
endinterface

// File: rtl/dmi_dtm_core.sv
// JTAG DTM core: dtmcs and DMI data registers plus the DMI
// request/response sequencer, all in the tck domain.
module dmi_dtm_core #(
  parameter int unsigned AddrWidth = 7,
  parameter logic [2:0]  IdleHint  = 3'd1,
  parameter logic [3:0]  Version   = 4'd1
) (
  input  logic tck_i,
  input  logic trst_ni,
  input  logic capture_i,
  input  logic shift_i,
  input  logic update_i,
  input  logic tdi_i,
  input  logic dtmcs_select_i,
  input  logic dmi_select_i,
  output logic dtmcs_tdo_o,
  output logic dmi_tdo_o,
  output logic dmi_clear_o,
  dmi_dtm_core_if.master dmi
);
  localparam int unsigned DrWidth = AddrWidth + 34;
  localparam logic [5:0]  Abits   = 6'(AddrWidth);

  typedef enum logic [2:0] {
    Idle, Read, WaitRead, Write, WaitWrite
  } state_e;

  state_e               state_q;
  logic [1:0]           error_q;
  logic [1:0]           op_q;
  logic [31:0]          dtmcs_q;
  logic [31:0]          data_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DrWidth-1:0]   dr_q;
  logic                 valid_q;
  logic                 clear_q;

  logic                 dtmcs_upd;
  logic                 hardreset;
  logic                 dmireset;
  logic                 dmi_cap;
  logic                 dmi_upd;
  logic                 idle;
  logic                 resp_done;
  logic [1:0]           st;
  logic [1:0]           dr_op;
  logic [31:0]          dr_data;
  logic [AddrWidth-1:0] dr_addr;

  assign dtmcs_upd = update_i & dtmcs_select_i;
  assign hardreset = dtmcs_upd & dtmcs_q[17];
  assign dmireset  = dtmcs_upd & dtmcs_q[16];
  assign dmi_cap   = capture_i & dmi_select_i;
  assign dmi_upd   = update_i & dmi_select_i;
  assign idle      = (state_q == Idle);
  assign resp_done = dmi.dmi_resp_valid_i &
                     (state_q == WaitRead ||
                      state_q == WaitWrite);

  assign st = (error_q != 2'd0) ? error_q :
              (idle ? 2'd0 : 2'd3);

  assign dr_op   = dr_q[1:0];
  assign dr_data = dr_q[33:2];
  assign dr_addr = dr_q[DrWidth-1:34];

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      dtmcs_q <= '0;
      dr_q    <= '0;
    end else begin
      if (capture_i && dtmcs_select_i)
        dtmcs_q <= {14'b0, 3'b0, IdleHint,
                    error_q, Abits, Version};
      else if (shift_i && dtmcs_select_i)
        dtmcs_q <= {tdi_i, dtmcs_q[31:1]};
      if (dmi_cap)
        dr_q <= {addr_q, data_q, st};
      else if (shift_i && dmi_select_i)
        dr_q <= {tdi_i, dr_q[DrWidth-1:1]};
    end
  end

  // A response code of 1 is reserved and leaves the error untouched.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      error_q <= 2'd0;
    end else if (hardreset || dmireset) begin
      error_q <= 2'd0;
    end else if (!idle && (dmi_cap || dmi_upd)) begin
      error_q <= 2'd3;
    end else if (resp_done && dmi.dmi_resp_resp_i[1]) begin
      error_q <= dmi.dmi_resp_resp_i;
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q <= Idle;
      valid_q <= 1'b0;
      clear_q <= 1'b0;
      op_q    <= 2'd0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      clear_q <= hardreset;
      if (hardreset) begin
        state_q <= Idle;
        valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          Idle: begin
            if (dmi_upd && error_q == 2'd0) begin
              addr_q <= dr_addr;
              data_q <= dr_data;
              if (dr_op == 2'd1) begin
                state_q <= Read;
                valid_q <= 1'b1;
                op_q    <= 2'd1;
              end else if (dr_op == 2'd2) begin
                state_q <= Write;
                valid_q <= 1'b1;
                op_q    <= 2'd2;
              end
            end
          end
          Read: begin
            if (dmi.dmi_req_ready_i) begin
              state_q <= WaitRead;
              valid_q <= 1'b0;
            end
          end
          Write: begin
            if (dmi.dmi_req_ready_i) begin
              state_q <= WaitWrite;
              valid_q <= 1'b0;
            end
          end
          WaitRead: begin
            if (dmi.dmi_resp_valid_i) begin
              state_q <= Idle;
              data_q  <= dmi.dmi_resp_data_i;
            end
          end
          WaitWrite: begin
            if (dmi.dmi_resp_valid_i)
              state_q <= Idle;
          end
          default: begin
            state_q <= Idle;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dtmcs_tdo_o          = dtmcs_q[0];
  assign dmi_tdo_o            = dr_q[0];
  assign dmi_clear_o          = clear_q;
  assign dmi.dmi_req_valid_o  = valid_q;
  assign dmi.dmi_req_addr_o   = addr_q;
  assign dmi.dmi_req_op_o     = op_q;
  assign dmi.dmi_req_data_o   = data_q;
  assign dmi.dmi_resp_ready_o = 1'b1;
endmodule

// File: tb/tb_dmi_dtm_core.sv
// Bench for dmi_dtm_core: directed scenarios plus random DMI
// traffic checked against a transaction-level model.
module tb_dmi_dtm_core;
  localparam int AW  = 7;
  localparam int DRW = AW + 34;

  logic tck = 1'b0;
  logic trst_n = 1'b0;
  logic capture = 1'b0;
  logic shift = 1'b0;
  logic update = 1'b0;
  logic tdi = 1'b0;
  logic dtmcs_sel = 1'b0;
  logic dmi_sel = 1'b0;
  logic dtmcs_tdo;
  logic dmi_tdo;
  logic dmi_clear;

  dmi_dtm_core_if #(.AddrWidth(AW)) dmi ();

  dmi_dtm_core #(.AddrWidth(AW)) dut (
    .tck_i          (tck),
    .trst_ni        (trst_n),
    .capture_i      (capture),
    .shift_i        (shift),
    .update_i       (update),
    .tdi_i          (tdi),
    .dtmcs_select_i (dtmcs_sel),
    .dmi_select_i   (dmi_sel),
    .dtmcs_tdo_o    (dtmcs_tdo),
    .dmi_tdo_o      (dmi_tdo),
    .dmi_clear_o    (dmi_clear),
    .dmi            (dmi)
  );

  always #5 tck = ~tck;

  int checks = 0;
  int errors = 0;

  // reference model: what the debugger would believe
  logic [AW-1:0] m_addr = '0;
  logic [31:0]   m_data = '0;
  logic [1:0]    m_err  = '0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic scan(input bit dm, input logic [63:0] din,
                      input int n, input bit upd,
                      output logic [63:0] dout);
    dout = '0;
    @(negedge tck);
    capture = 1'b1;
    dtmcs_sel = !dm;
    dmi_sel = dm;
    for (int i = 0; i < n; i++) begin
      @(negedge tck);
      capture = 1'b0;
      shift = 1'b1;
      dout[i] = dm ? dmi_tdo : dtmcs_tdo;
      tdi = din[i];
    end
    @(negedge tck);
    shift = 1'b0;
    tdi = 1'b0;
    update = upd;
    @(negedge tck);
    update = 1'b0;
  endtask

  task automatic dtmcs_write(input logic [31:0] val);
    logic [63:0] d;
    logic [31:0] exp;
    exp = 32'h1000 | (32'(AW) << 4) | 32'h1 | (32'(m_err) << 10);
    scan(1'b0, 64'(val), 32, 1'b1, d);
    check("dtmcs_cap", d, 64'(exp));
    check("clear_pulse", 64'(dmi_clear), 64'(val[17]));
    if (val[17]) check("hard_valid", 64'(dmi.dmi_req_valid_o), 64'd0);
    if (val[17] || val[16]) m_err = 2'd0;
    @(negedge tck);
    check("clear_end", 64'(dmi_clear), 64'd0);
  endtask

  task automatic cap_check(input string tag);
    logic [63:0] d;
    logic [63:0] exp;
    exp = '0;
    exp[DRW-1:0] = {m_addr, m_data, m_err};
    scan(1'b1, {$urandom, $urandom}, DRW, 1'b0, d);
    check(tag, d, exp);
  endtask

  task automatic dmi_txn(input logic [AW-1:0] addr,
                         input logic [31:0] data,
                         input logic [1:0] op,
                         input int rdly, input logic [1:0] resp,
                         input logic [31:0] rdata,
                         input bit probe);
    logic [63:0] d;
    logic [63:0] exp;
    bit acc;
    acc = (m_err == 2'd0);
    scan(1'b1, 64'({addr, data, op}), DRW, 1'b1, d);
    if (acc) begin
      m_addr = addr;
      m_data = data;
    end
    if (acc && (op == 2'd1 || op == 2'd2)) begin
      check("req_valid", 64'(dmi.dmi_req_valid_o), 64'd1);
      repeat (rdly) begin
        @(negedge tck);
        check("valid_hold", 64'(dmi.dmi_req_valid_o), 64'd1);
      end
      check("req_addr", 64'(dmi.dmi_req_addr_o), 64'(addr));
      check("req_op", 64'(dmi.dmi_req_op_o), 64'(op));
      check("req_data", 64'(dmi.dmi_req_data_o), 64'(data));
      dmi.dmi_req_ready_i = 1'b1;
      @(negedge tck);
      dmi.dmi_req_ready_i = 1'b0;
      check("valid_drop", 64'(dmi.dmi_req_valid_o), 64'd0);
      if (probe) begin
        exp = '0;
        exp[DRW-1:0] = {m_addr, m_data, 2'd3};
        scan(1'b1, 64'd0, DRW, 1'b0, d);
        check("busy_cap", d, exp);
        m_err = 2'd3;
      end
      repeat ($urandom_range(0, 2)) @(negedge tck);
      dmi.dmi_resp_valid_i = 1'b1;
      dmi.dmi_resp_data_i = rdata;
      dmi.dmi_resp_resp_i = resp;
      @(negedge tck);
      dmi.dmi_resp_valid_i = 1'b0;
      if (op == 2'd1) m_data = rdata;
      if (resp >= 2'd2) m_err = resp;
    end else begin
      check("no_req", 64'(dmi.dmi_req_valid_o), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] d;
    logic [1:0] rs;
    dmi.dmi_req_ready_i = 1'b0;
    dmi.dmi_resp_valid_i = 1'b0;
    dmi.dmi_resp_data_i = '0;
    dmi.dmi_resp_resp_i = '0;
    repeat (2) @(negedge tck);
    check("rst_valid", 64'(dmi.dmi_req_valid_o), 64'd0);
    check("rst_clear", 64'(dmi_clear), 64'd0);
    check("rst_dmi_tdo", 64'(dmi_tdo), 64'd0);
    check("rst_dtmcs_tdo", 64'(dtmcs_tdo), 64'd0);
    check("rst_ready", 64'(dmi.dmi_resp_ready_o), 64'd1);
    trst_n = 1'b1;

    scan(1'b0, 64'd0, 32, 1'b0, d);
    check("dtmcs_reset", d, 64'h1071);
    cap_check("dmi_reset_cap");

    dmi_txn(7'h10, 32'hDEADBEEF, 2'd2, 3, 2'd0, 32'd0, 1'b0);
    cap_check("write_cap");
    dmi_txn(7'h04, 32'h0, 2'd1, 0, 2'd0, 32'h12345678, 1'b0);
    cap_check("read_cap");

    dmi_txn(7'h22, 32'h5, 2'd1, 1, 2'd0, 32'hCAFEF00D, 1'b1);
    cap_check("sticky_cap");
    dmi_txn(7'h33, 32'h77, 2'd2, 0, 2'd0, 32'd0, 1'b0);
    cap_check("ignored_cap");
    dtmcs_write(32'h0001_0000);
    cap_check("dmireset_cap");

    dmi_txn(7'h11, 32'hA5A5A5A5, 2'd2, 2, 2'd2, 32'd0, 1'b0);
    dtmcs_write(32'h0);
    dmi_txn(7'h12, 32'h1, 2'd1, 0, 2'd0, 32'd9, 1'b0);
    dtmcs_write(32'h0001_0000);
    cap_check("fail_clr_cap");

    // hardreset while a read waits for ready
    scan(1'b1, 64'({7'h05, 32'h0BAD0BAD, 2'd1}), DRW, 1'b1, d);
    m_addr = 7'h05;
    m_data = 32'h0BAD0BAD;
    check("hr_valid", 64'(dmi.dmi_req_valid_o), 64'd1);
    dtmcs_write(32'h0002_0000);
    check("hr_valid_low", 64'(dmi.dmi_req_valid_o), 64'd0);
    cap_check("hr_cap");

    // reset in the middle of a read abandons it
    scan(1'b1, 64'({7'h06, 32'h1, 2'd1}), DRW, 1'b1, d);
    dmi.dmi_req_ready_i = 1'b1;
    @(negedge tck);
    dmi.dmi_req_ready_i = 1'b0;
    trst_n = 1'b0;
    @(negedge tck);
    trst_n = 1'b1;
    m_addr = '0;
    m_data = '0;
    m_err = '0;
    dmi.dmi_resp_valid_i = 1'b1;
    dmi.dmi_resp_data_i = 32'hAAAA5555;
    dmi.dmi_resp_resp_i = 2'd2;
    @(negedge tck);
    dmi.dmi_resp_valid_i = 1'b0;
    check("rst_mid_valid", 64'(dmi.dmi_req_valid_o), 64'd0);
    cap_check("rst_mid_cap");

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        3: rs = 2'd2;
        4: rs = 2'd3;
        default: rs = 2'd0;
      endcase
      dmi_txn(AW'($urandom), $urandom, 2'($urandom_range(0, 3)),
              $urandom_range(0, 3), rs, $urandom,
              $urandom_range(0, 4) == 0);
      cap_check("rand_cap");
      if ($urandom_range(0, 3) == 0) dtmcs_write(32'h0001_0000);
      else if ($urandom_range(0, 3) == 0) dtmcs_write(32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
